// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared definitions for the multi-lane serializer slice: the FSM state
// encoding and the helpers that size the beat counter from the word/lane
// geometry.
//
// Optional feature macro: SERIALIZER_PARITY_EN adds a PARITY state that
// emits one even-parity beat after the last data beat of every word.
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;
`endif

  // Number of LANES-wide beats needed to emit one WIDTH-bit word.
  function automatic int calc_beats(input int width, input int lanes);
    return width / lanes;
  endfunction

  // The counter must be able to hold BEATS itself, not just BEATS-1.
  function automatic int calc_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/serializer_hold_buf.sv
// serializer_hold_buf
// One-entry skid buffer that parks the next word while the current one is
// still being shifted out.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset (empties the buffer)
//   i_load  - capture iv_din and mark the entry valid
//   i_take  - release the entry (its word has moved to the shift register)
//   iv_din  - word to capture
//   ov_data - buffered word
//   o_valid - entry occupied
module serializer_hold_buf #(
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_take,
  input  logic [WIDTH-1:0] iv_din,
  output logic [WIDTH-1:0] ov_data,
  output logic             o_valid
);

  import serializer_pkg::*;

  // Load and take are never requested together by the serializer; if they
  // ever were, keeping the newly loaded word is the safe choice.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_data <= '0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      ov_data <= iv_din;
      o_valid <= 1'b1;
    end else if (i_take) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serializer_mlane.sv
// serializer_mlane
// Parallel-to-serial converter: accepts WIDTH-bit words with a valid/ready
// handshake and emits them as WIDTH/LANES beats of LANES bits each, with a
// one-word hold buffer so consecutive words stream without a bubble.
//
// Parameters:
//   WIDTH     - input word width (must be a multiple of LANES)
//   LANES     - output bits per beat
//   MSB_FIRST - 0: lowest LANES bits first, 1: highest LANES bits first
//
// Ports:
//   i_clk        - clock, rising edge
//   i_rst        - asynchronous active-high reset
//   i_en         - clock enable; low freezes all state and handshakes
//   iv_din       - parallel word
//   i_din_valid  - iv_din valid
//   o_din_ready  - word accepted when i_din_valid && o_din_ready
//   ov_dout      - current beat
//   o_dout_valid - ov_dout valid
//   i_dout_ready - beat consumed when o_dout_valid && i_dout_ready
//   o_dout_last  - marks the final beat of a word
//   o_busy       - word in flight or hold buffer occupied
//
// Optional feature macro: SERIALIZER_PARITY_EN appends an even-parity beat
// (parity on lane 0, other lanes 0) after each word; o_dout_last then marks
// the parity beat instead of the last data beat.
module serializer_mlane #(
  parameter int WIDTH     = 24,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] iv_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  output logic [LANES-1:0] ov_dout,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_dout_last,
  output logic             o_busy
);

  import serializer_pkg::*;

  localparam int BEATS = calc_beats(WIDTH, LANES);
  localparam int CNT_W = calc_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  if (WIDTH % LANES != 0) begin : g_bad_lanes
    $error("serializer_mlane: WIDTH must be a multiple of LANES");
  end

  ser_state_t       state_q;
  ser_state_t       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic [WIDTH-1:0] load_word;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q;
`endif

  logic accept;
  logic beat_hs;
  logic data_last;
  logic final_beat;
  logic load_din;
  logic load_hold;
  logic hold_load;
  logic hold_take;
  logic advance;
  logic word_done;

  assign o_din_ready  = i_en && !hold_valid;
  assign accept       = i_din_valid && o_din_ready;
  assign o_dout_valid = valid_q && i_en;
  assign beat_hs      = o_dout_valid && i_dout_ready;
  assign data_last    = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
`ifdef SERIALIZER_PARITY_EN
  assign final_beat   = (state_q == ST_PARITY);
`else
  assign final_beat   = data_last;
`endif
  assign o_dout_last  = final_beat;
  assign o_busy       = (state_q != ST_IDLE) || hold_valid;
  assign load_word    = load_hold ? hold_data : iv_din;

  serializer_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (hold_load),
    .i_take  (hold_take),
    .iv_din  (iv_din),
    .ov_data (hold_data),
    .o_valid (hold_valid)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control. At the end of a word the hold buffer
  // has priority; if it is empty, a word arriving in that same cycle goes
  // straight into the shift register so the stream never bubbles.
  always_comb begin
    state_d   = state_q;
    load_din  = 1'b0;
    load_hold = 1'b0;
    hold_load = 1'b0;
    hold_take = 1'b0;
    advance   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          load_din = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (beat_hs) begin
          if (final_beat) begin
            word_done = 1'b1;
          end else begin
            advance = 1'b1;
`ifdef SERIALIZER_PARITY_EN
            if (data_last) begin
              state_d = ST_PARITY;
            end
`endif
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      ST_PARITY: begin
        if (beat_hs) begin
          word_done = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (word_done) begin
      if (hold_valid) begin
        load_hold = 1'b1;
        hold_take = 1'b1;
        state_d   = ST_SHIFT;
      end else if (accept) begin
        load_din = 1'b1;
        state_d  = ST_SHIFT;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (accept && (state_q != ST_IDLE)) begin
      hold_load = 1'b1;
    end
  end

  // Shift register, beat counter and output-valid flag. Any reset throws
  // away a partially emitted word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else if (load_din || load_hold) begin
      shreg_q  <= load_word;
      cnt_q    <= '0;
      valid_q  <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_q <= ^load_word;
`endif
    end else if (advance) begin
      if (MSB_FIRST != 0) begin
        shreg_q <= shreg_q << LANES;
      end else begin
        shreg_q <= shreg_q >> LANES;
      end
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (word_done) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end
  end

  // The current beat always sits at the outgoing end of the shift register.
  always_comb begin
    if (MSB_FIRST != 0) begin
      ov_dout = shreg_q[WIDTH-1 -: LANES];
    end else begin
      ov_dout = shreg_q[LANES-1:0];
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_q == ST_PARITY) begin
      ov_dout    = '0;
      ov_dout[0] = parity_q;
    end
`endif
  end

endmodule
